// File: rtl/note_tone_synth.sv
// note_tone_synth
//   Audio back end for the pitch game. Turns the note request vector from the game
//   controller into an enveloped square-wave tone, delivered as PWM on aud_pwm, and
//   drives aud_sd to enable the board amplifier while a tone is active.
//
// Ports
//   clk_in        in   1  system clock (100 MHz)
//   rst_n_in      in   1  asynchronous active-low reset
//   enable_in     in   1  tone output permitted
//   note_in       in   7  note request, bit0=C4 .. bit6=B4, lowest set bit wins, 0 = silence
//   volume_in     in   3  amplitude target select, 0 = mute
//   octave_in     in   2  octave select 0..3 = octave 4..7 (only with NOTE_TONE_OCTAVE_EN)
//   aud_pwm       out  1  PWM audio
//   aud_sd        out  1  amplifier enable, high while not IDLE
//   note_idx_out  out  3  index of the sounding note, 7 = none
//   busy_out      out  1  high in ATTACK/SUSTAIN/RELEASE
//
// Build option
//   NOTE_TONE_OCTAVE_EN : adds octave_in; half-period is further shifted right by it.
//
// State     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | silent, amp held at 0, amplifier off
// ST_ATTACK | amp rising one LSB per envelope tick toward the target
// ST_SUSTAIN| amp tracks the volume target by +/-1 per tick
// ST_RELEASE| amp falling one LSB per tick; IDLE once it reaches 0
module note_tone_synth #(
  parameter int PWM_BITS       = 8,
  parameter int RAMP_DIV       = 4096,
  parameter int TONE_DIV_SHIFT = 0
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       enable_in,
  input  logic [6:0] note_in,
  input  logic [2:0] volume_in,
`ifdef NOTE_TONE_OCTAVE_EN
  input  logic [1:0] octave_in,
`endif
  output logic       aud_pwm,
  output logic       aud_sd,
  output logic [2:0] note_idx_out,
  output logic       busy_out
);

  localparam int TICK_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(RAMP_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ATTACK  = 2'd1,
    ST_SUSTAIN = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  // Half-period of one note in clocks, after the simulation shift and octave shift.
  function automatic logic [17:0] half_period(input logic [2:0] idx, input logic [1:0] oct);
    logic [17:0] base;
    case (idx)
      3'd0:    base = 18'd191113;
      3'd1:    base = 18'd170265;
      3'd2:    base = 18'd151686;
      3'd3:    base = 18'd143173;
      3'd4:    base = 18'd127551;
      3'd5:    base = 18'd113636;
      3'd6:    base = 18'd101239;
      default: base = 18'd0;
    endcase
    return (base >> TONE_DIV_SHIFT) >> oct;
  endfunction

  // The counter runs reload..0 inclusive, so loading half-1 makes every half-cycle
  // last exactly half-period clocks. Degenerate tiny periods clamp to 1 clock.
  function automatic logic [17:0] phase_reload(input logic [2:0] idx, input logic [1:0] oct);
    logic [17:0] h;
    h = half_period(idx, oct);
    return (h > 18'd1) ? (h - 18'd1) : 18'd0;
  endfunction

  // input register stage
  logic                en_q, en_d;
  logic [6:0]          note_q, note_d;
  logic [2:0]          vol_q, vol_d;
  logic [1:0]          oct_q, oct_d;

  state_t              state_q, state_d;
  logic [PWM_BITS-1:0] amp_q, amp_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [17:0]         phase_cnt_q, phase_cnt_d;
  logic                sq_q, sq_d;
  logic [2:0]          idx_q, idx_d;
  logic [1:0]          oct_act_q, oct_act_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                aud_pwm_q, aud_pwm_d;
  logic                aud_sd_q, aud_sd_d;
  logic                busy_q, busy_d;

  logic                tick;
  logic                note_nz;
  logic                go;
  logic [2:0]          req_idx;
  logic [7:0]          target8;
  logic [PWM_BITS-1:0] target;
  logic [PWM_BITS-1:0] sample;

  always_comb begin
    en_d   = enable_in;
    note_d = note_in;
    vol_d  = volume_in;
`ifdef NOTE_TONE_OCTAVE_EN
    oct_d  = octave_in;
`else
    oct_d  = 2'd0;
`endif
  end

  // request decode: lowest set bit wins
  always_comb begin
    req_idx = 3'd7;
    for (int i = 6; i >= 0; i--) begin
      if (note_q[i]) req_idx = 3'(i);
    end
    note_nz = |note_q;
    go      = en_q & note_nz;
    // replicating the 3-bit volume spreads 1..7 evenly over the 8-bit range (7 -> 255)
    target8 = {vol_q, vol_q, vol_q[2:1]};
    target  = PWM_BITS'(target8);
  end

  // free-running envelope prescaler
  always_comb begin
    tick       = (tick_cnt_q == '0);
    tick_cnt_d = tick ? TICK_RELOAD : (tick_cnt_q - 1'b1);
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (go) state_d = ST_ATTACK;
      ST_ATTACK: begin
        if (!go)                  state_d = ST_RELEASE;
        else if (amp_q >= target) state_d = ST_SUSTAIN;
      end
      ST_SUSTAIN: if (!go) state_d = ST_RELEASE;
      ST_RELEASE: begin
        if (go)                state_d = ST_ATTACK;
        else if (amp_q == '0)  state_d = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // envelope: a tick coinciding with a transition follows the new state's rule
  always_comb begin
    amp_d = amp_q;
    if (state_d == ST_IDLE) begin
      amp_d = '0;
    end else if (tick) begin
      case (state_d)
        ST_ATTACK:  if (amp_q < target) amp_d = amp_q + 1'b1;
        ST_SUSTAIN: begin
          if (amp_q < target)      amp_d = amp_q + 1'b1;
          else if (amp_q > target) amp_d = amp_q - 1'b1;
        end
        ST_RELEASE: if (amp_q != '0) amp_d = amp_q - 1'b1;
        default:    amp_d = amp_q;
      endcase
    end
  end

  // tone phase; note/octave changes while sounding wait for the next reload
  always_comb begin
    phase_cnt_d = phase_cnt_q;
    sq_d        = sq_q;
    idx_d       = idx_q;
    oct_act_d   = oct_act_q;
    if (state_d == ST_IDLE) begin
      phase_cnt_d = '0;
      sq_d        = 1'b0;
      idx_d       = 3'd7;
      oct_act_d   = 2'd0;
    end else if (state_q == ST_IDLE) begin
      idx_d       = req_idx;
      oct_act_d   = oct_q;
      phase_cnt_d = phase_reload(req_idx, oct_q);
      sq_d        = 1'b0;
    end else if (phase_cnt_q == '0) begin
      sq_d = ~sq_q;
      if (note_nz) begin
        idx_d     = req_idx;
        oct_act_d = oct_q;
      end
      phase_cnt_d = phase_reload(idx_d, oct_act_d);
    end else begin
      phase_cnt_d = phase_cnt_q - 18'd1;
    end
  end

  // PWM and status outputs
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    sample    = sq_q ? amp_q : '0;
    aud_pwm_d = (pwm_cnt_q < sample);
    aud_sd_d  = (state_d != ST_IDLE);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      en_q        <= 1'b0;
      note_q      <= '0;
      vol_q       <= '0;
      oct_q       <= '0;
      state_q     <= ST_IDLE;
      amp_q       <= '0;
      tick_cnt_q  <= TICK_RELOAD;
      phase_cnt_q <= '0;
      sq_q        <= 1'b0;
      idx_q       <= 3'd7;
      oct_act_q   <= '0;
      pwm_cnt_q   <= '0;
      aud_pwm_q   <= 1'b0;
      aud_sd_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      en_q        <= en_d;
      note_q      <= note_d;
      vol_q       <= vol_d;
      oct_q       <= oct_d;
      state_q     <= state_d;
      amp_q       <= amp_d;
      tick_cnt_q  <= tick_cnt_d;
      phase_cnt_q <= phase_cnt_d;
      sq_q        <= sq_d;
      idx_q       <= idx_d;
      oct_act_q   <= oct_act_d;
      pwm_cnt_q   <= pwm_cnt_d;
      aud_pwm_q   <= aud_pwm_d;
      aud_sd_q    <= aud_sd_d;
      busy_q      <= busy_d;
    end
  end

  assign aud_pwm      = aud_pwm_q;
  assign aud_sd       = aud_sd_q;
  assign note_idx_out = idx_q;
  assign busy_out     = busy_q;

endmodule

// File: tb/tb_note_tone_synth.sv
module tb_note_tone_synth;

  localparam int RAMP_DIV = 4;
  localparam int SHIFT    = 8;
  localparam int S_IDLE = 0, S_ATT = 1, S_SUS = 2, S_REL = 3;

  logic       clk_in    = 1'b0;
  logic       rst_n_in  = 1'b0;
  logic       enable_in = 1'b0;
  logic [6:0] note_in   = '0;
  logic [2:0] volume_in = '0;
  logic       aud_pwm, aud_sd, busy_out;
  logic [2:0] note_idx_out;

  int total = 0;
  int bad   = 0;

  note_tone_synth #(.PWM_BITS(8), .RAMP_DIV(RAMP_DIV), .TONE_DIV_SHIFT(SHIFT)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .enable_in(enable_in), .note_in(note_in),
    .volume_in(volume_in), .aud_pwm(aud_pwm), .aud_sd(aud_sd),
    .note_idx_out(note_idx_out), .busy_out(busy_out));

  always #5 clk_in = ~clk_in;

  // ---------------- reference model ----------------
  function automatic int half_clks(int i);
    int full;
    case (i)
      0: full = 191113; 1: full = 170265; 2: full = 151686; 3: full = 143173;
      4: full = 127551; 5: full = 113636; default: full = 101239;
    endcase
    return full / (1 << SHIFT);
  endfunction

  function automatic int low_bit(logic [6:0] n);
    for (int i = 0; i < 7; i++) if (n[i]) return i;
    return 7;
  endfunction

  // volume code v maps to round(v*255/7)
  function automatic int vol_target(int v);
    return (v * 255 + 3) / 7;
  endfunction

  logic [5:0] exp_q[$];
  int   m_n, m_stage, m_amp, m_left, m_cur, m_vol, m_prev, m_tgt;
  bit   m_sq, m_en, m_tick, m_want, m_pwm, m_on;
  logic [6:0] m_note;

  task automatic model_reset();
    m_n = 0; m_stage = S_IDLE; m_amp = 0; m_left = 0; m_cur = 7; m_sq = 0;
    m_en = 0; m_note = '0; m_vol = 0;
    exp_q.delete();
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_in or negedge rst_n_in);
      if (!rst_n_in) begin
        model_reset();
      end else begin
        m_n++;
        m_tick = (m_n % RAMP_DIV) == 0;
        m_want = m_en && (m_note != 0);
        m_tgt  = vol_target(m_vol);
        m_pwm  = ((m_n - 1) % 256) < (m_sq ? m_amp : 0);
        m_prev = m_stage;
        case (m_stage)
          S_IDLE: if (m_want) m_stage = S_ATT;
          S_ATT:  if (!m_want) m_stage = S_REL; else if (m_amp >= m_tgt) m_stage = S_SUS;
          S_SUS:  if (!m_want) m_stage = S_REL;
          default: if (m_want) m_stage = S_ATT; else if (m_amp == 0) m_stage = S_IDLE;
        endcase
        if (m_stage == S_IDLE) m_amp = 0;
        else if (m_tick) begin
          if (m_stage == S_ATT && m_amp < m_tgt) m_amp++;
          else if (m_stage == S_SUS) m_amp += (m_tgt > m_amp) - (m_tgt < m_amp);
          else if (m_stage == S_REL && m_amp > 0) m_amp--;
        end
        if (m_stage == S_IDLE) begin
          m_sq = 0; m_left = 0; m_cur = 7;
        end else if (m_prev == S_IDLE) begin
          m_cur = low_bit(m_note); m_left = half_clks(m_cur); m_sq = 0;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_sq = !m_sq;
            if (m_note != 0) m_cur = low_bit(m_note);
            m_left = half_clks(m_cur);
          end
        end
        m_on = (m_stage != S_IDLE);
        exp_q.push_back({m_pwm, m_on, m_on, 3'(m_cur)});
        m_en = enable_in; m_note = note_in; m_vol = int'(volume_in);
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [5:0] e, a;
    forever begin
      @(negedge clk_in);
      if (rst_n_in && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {aud_pwm, aud_sd, busy_out, note_idx_out};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL outputs t=%0t {pwm,sd,busy,idx} actual=%b required=%b", $time, a, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic chk(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic cyc(int k);
    repeat (k) @(negedge clk_in);
  endtask

  task automatic wait_idle(int budget, string name);
    int k = 0;
    while (busy_out !== 1'b0 && k < budget) begin @(negedge clk_in); k++; end
    chk(name, int'(busy_out), 0);
  endtask

  task automatic wait_idx(int want, int budget, string name);
    int k = 0;
    while (int'(note_idx_out) != want && k < budget) begin @(negedge clk_in); k++; end
    chk(name, int'(note_idx_out), want);
  endtask

  initial begin
    int highs;
    cyc(2);
    chk("rst_pwm", int'(aud_pwm), 0);
    chk("rst_sd", int'(aud_sd), 0);
    chk("rst_idx", int'(note_idx_out), 7);
    chk("rst_busy", int'(busy_out), 0);
    #2 rst_n_in = 1'b1;
    cyc(1);

    // A4 attack to full scale
    enable_in = 1'b1; volume_in = 3'd7; note_in = 7'b0100000;
    cyc(3);
    chk("a4_idx", int'(note_idx_out), 5);
    chk("a4_busy", int'(busy_out), 1);
    chk("a4_sd", int'(aud_sd), 1);
    cyc(1100);
    chk("a4_sustain_busy", int'(busy_out), 1);

    // release to idle
    note_in = '0;
    wait_idle(1200, "rel_to_idle");
    chk("idle_sd", int'(aud_sd), 0);
    chk("idle_idx", int'(note_idx_out), 7);

    // two bits set -> C4 wins
    note_in = 7'b0000011;
    cyc(3);
    chk("c4_idx", int'(note_idx_out), 0);
    cyc(1200);

    // note changes take effect only at the next half-cycle boundary
    note_in = 7'b0100000;
    wait_idx(5, 760, "c4_to_a4");
    cyc(300);
    note_in = 7'b0000001;
    wait_idx(0, 450, "a4_to_c4");

    // volume changes in sustain, then mute
    volume_in = 3'd4;
    cyc(600);
    volume_in = 3'd0;
    cyc(1100);
    highs = 0;
    repeat (300) begin @(negedge clk_in); if (aud_pwm) highs++; end
    chk("mute_pwm_highs", highs, 0);
    chk("mute_busy", int'(busy_out), 1);

    // async reset mid-sustain
    volume_in = 3'd7;
    cyc(1100);
    #3 rst_n_in = 1'b0;
    #1;
    chk("midrst_pwm", int'(aud_pwm), 0);
    chk("midrst_sd", int'(aud_sd), 0);
    chk("midrst_idx", int'(note_idx_out), 7);
    chk("midrst_busy", int'(busy_out), 0);
    cyc(2);
    #2 rst_n_in = 1'b1;
    cyc(600);

    // enable drop with note held
    enable_in = 1'b0;
    wait_idle(1200, "disable_to_idle");
    chk("disable_sd", int'(aud_sd), 0);

    // randomized stimulus
    for (int r = 0; r < 40; r++) begin
      @(negedge clk_in);
      enable_in = ($urandom_range(0, 7) != 0);
      note_in   = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      volume_in = 3'($urandom_range(0, 7));
      cyc($urandom_range(5, 800));
    end

    cyc(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
